// File: rtl/pc_sequencer.sv
// Program-counter sequencer for a multi-cycle core.
// Picks the next PC from one of several sources and applies unconditional
// or branch-conditional updates. Exceptions are handled in two steps: the
// faulting PC is saved first, and the PC is redirected to the handler on
// the following cycle.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       pc_source,
    input  logic             pc_write,
    input  logic             pc_write_cond,
    input  logic             branch_ne,
    input  logic             zero,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [25:0]      jump_target,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             exc_req,
    input  logic [1:0]       exc_code,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] epc,
    output logic [1:0]       cause,
    output logic             exc_busy,
    output logic             exc_ack
);

    // One-hot style encoding, so a corrupted state register can be detected
    // and steered back to RUN.
    typedef enum logic [1:0] {
        ST_RUN = 2'b01,
        ST_EXC = 2'b10
    } state_t;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b11;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic [1:0]       r_cause;
    logic             r_exc_busy;
    logic             r_exc_ack;

    logic [WIDTH-1:0] w_cand;
    logic             w_take;
    logic             w_misalign;

    // Branch is taken when the zero flag disagrees with the BNE sense bit.
    assign w_take     = pc_write | (pc_write_cond & (zero ^ branch_ne));
    assign w_misalign = (w_cand[1:0] != 2'b00);

    // Candidate next-PC mux; the reserved codes keep the current PC.
    always_comb begin
        w_cand = r_pc;
        case (pc_source)
            3'b000:  w_cand = alu_result;
            3'b001:  w_cand = alu_out;
            3'b010:  w_cand = {r_pc[WIDTH-1:28], jump_target, 2'b00};
            3'b011:  w_cand = EXC_VECTOR;
            3'b100:  w_cand = r_epc;
            3'b110:  w_cand = mem_data;
            default: w_cand = r_pc;
        endcase
    end

    // Sequencer FSM. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_VECTOR;
            r_epc      <= '0;
            r_cause    <= 2'b00;
            r_exc_busy <= 1'b0;
            r_exc_ack  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_exc_ack <= 1'b0;
                    if (exc_req) begin
                        // External request wins; any pending PC update is dropped.
                        r_epc      <= r_pc;
                        r_cause    <= exc_code;
                        r_exc_busy <= 1'b1;
                        r_state    <= ST_EXC;
                    end else if (w_take) begin
                        if (w_misalign) begin
                            // Never load a misaligned PC; trap on the current one instead.
                            r_epc      <= r_pc;
                            r_cause    <= CAUSE_MISALIGN;
                            r_exc_busy <= 1'b1;
                            r_state    <= ST_EXC;
                        end else begin
                            r_pc <= w_cand;
                        end
                    end
                end
                ST_EXC: begin
                    // Redirect to the handler and acknowledge in the first RUN cycle.
                    r_pc       <= EXC_VECTOR;
                    r_exc_busy <= 1'b0;
                    r_exc_ack  <= 1'b1;
                    r_state    <= ST_RUN;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_exc_busy <= 1'b0;
                    r_exc_ack  <= 1'b0;
                end
            endcase
        end
    end

    assign pc       = r_pc;
    assign epc      = r_epc;
    assign cause    = r_cause;
    assign exc_busy = r_exc_busy;
    assign exc_ack  = r_exc_ack;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic [2:0]  pc_source;
    logic        pc_write;
    logic        pc_write_cond;
    logic        branch_ne;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] alu_out;
    logic [25:0] jump_target;
    logic [31:0] mem_data;
    logic        exc_req;
    logic [1:0]  exc_code;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        exc_busy;
    logic        exc_ack;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h0000_0080)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_source     (pc_source),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .zero          (zero),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .jump_target   (jump_target),
        .mem_data      (mem_data),
        .exc_req       (exc_req),
        .exc_code      (exc_code),
        .pc            (pc),
        .epc           (epc),
        .cause         (cause),
        .exc_busy      (exc_busy),
        .exc_ack       (exc_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load the PC directly through the alu_result path.
    task automatic load_pc(input logic [31:0] v);
        pc_write      = 1'b1;
        pc_write_cond = 1'b0;
        pc_source     = 3'b000;
        alu_result    = v;
        step();
        pc_write      = 1'b0;
    endtask

    initial begin
        reset = 1'b0; pc_source = 3'b000; pc_write = 1'b0; pc_write_cond = 1'b0;
        branch_ne = 1'b0; zero = 1'b0; alu_result = 32'h0; alu_out = 32'h0;
        jump_target = 26'h0; mem_data = 32'h0; exc_req = 1'b0; exc_code = 2'b00;
        // Drive some junk while in reset; it must be overridden.
        pc_write = 1'b1; alu_result = 32'h0000_1234; exc_req = 1'b1; exc_code = 2'b10;
        step();
        step();
        chk("rst_pc",    pc, 32'h0);
        chk("rst_epc",   epc, 32'h0);
        chk("rst_cause", {30'd0, cause}, 32'h0);
        chk("rst_busy",  {31'd0, exc_busy}, 32'h0);
        chk("rst_ack",   {31'd0, exc_ack}, 32'h0);

        // First edge after reset release: PC+4 load.
        exc_req = 1'b0; exc_code = 2'b00;
        reset = 1'b1; pc_write = 1'b1; pc_source = 3'b000; alu_result = 32'h4;
        step();
        chk("first_pc4", pc, 32'h4);
        pc_write = 1'b0;

        // BEQ taken.
        load_pc(32'h1000);
        chk("set_1000", pc, 32'h1000);
        pc_write_cond = 1'b1; zero = 1'b1; branch_ne = 1'b0;
        pc_source = 3'b001; alu_out = 32'h1040;
        step();
        chk("beq_taken", pc, 32'h1040);
        // BNE with zero=1: not taken.
        load_pc(32'h1000);
        pc_write_cond = 1'b1; zero = 1'b1; branch_ne = 1'b1; pc_source = 3'b001;
        step();
        chk("bne_not_taken", pc, 32'h1000);
        // BNE with zero=0: taken.
        zero = 1'b0;
        step();
        chk("bne_taken", pc, 32'h1040);
        pc_write_cond = 1'b0;

        // Jump keeps upper nibble of current PC.
        load_pc(32'hA000_0010);
        pc_write = 1'b1; pc_source = 3'b010; jump_target = 26'h0000100;
        step();
        chk("jump", pc, 32'hA000_0400);
        // Reserved source holds.
        pc_source = 3'b101;
        step();
        chk("src101_hold", pc, 32'hA000_0400);
        pc_source = 3'b111;
        step();
        chk("src111_hold", pc, 32'hA000_0400);
        // Memory vector.
        pc_source = 3'b110; mem_data = 32'h0000_3000;
        step();
        chk("mem_vec", pc, 32'h0000_3000);
        // Exception vector as an ordinary source: no trap.
        pc_source = 3'b011;
        step();
        chk("src_excvec", pc, 32'h80);
        chk("src_excvec_busy", {31'd0, exc_busy}, 32'h0);
        pc_write = 1'b0;

        // External exception with a competing pc_write.
        load_pc(32'h20);
        exc_req = 1'b1; exc_code = 2'b01; pc_write = 1'b1; pc_source = 3'b000; alu_result = 32'h100;
        step();
        chk("exc_epc",   epc, 32'h20);
        chk("exc_cause", {30'd0, cause}, 32'h1);
        chk("exc_busy",  {31'd0, exc_busy}, 32'h1);
        chk("exc_pc_held", pc, 32'h20);
        chk("exc_ack_low", {31'd0, exc_ack}, 32'h0);
        exc_req = 1'b0;
        step();
        chk("exc_redirect", pc, 32'h80);
        chk("exc_ack_hi",   {31'd0, exc_ack}, 32'h1);
        chk("exc_busy_lo",  {31'd0, exc_busy}, 32'h0);
        chk("exc_epc_keep", epc, 32'h20);
        pc_write = 1'b1; pc_source = 3'b100;
        step();
        chk("eret", pc, 32'h20);
        chk("eret_ack_lo", {31'd0, exc_ack}, 32'h0);
        pc_write = 1'b0;

        // Misaligned target traps instead of loading.
        load_pc(32'h40);
        pc_write = 1'b1; pc_source = 3'b000; alu_result = 32'h42;
        step();
        chk("mis_pc_held", pc, 32'h40);
        chk("mis_epc",     epc, 32'h40);
        chk("mis_cause",   {30'd0, cause}, 32'h3);
        chk("mis_busy",    {31'd0, exc_busy}, 32'h1);
        pc_write = 1'b0;
        step();
        chk("mis_redirect", pc, 32'h80);
        chk("mis_ack",      {31'd0, exc_ack}, 32'h1);

        // New request during the ack cycle is accepted.
        exc_req = 1'b1; exc_code = 2'b10;
        step();
        chk("ack_req_epc",   epc, 32'h80);
        chk("ack_req_cause", {30'd0, cause}, 32'h2);
        chk("ack_req_busy",  {31'd0, exc_busy}, 32'h1);
        chk("ack_req_acklo", {31'd0, exc_ack}, 32'h0);
        exc_req = 1'b0;
        step();
        chk("ack_req_ack", {31'd0, exc_ack}, 32'h1);
        load_pc(32'h200);
        chk("after_exc_load", pc, 32'h200);
        chk("epc_stable", epc, 32'h80);

        // Reset in the middle of EXC.
        exc_req = 1'b1; exc_code = 2'b01;
        step();
        chk("pre_rst_busy", {31'd0, exc_busy}, 32'h1);
        exc_req = 1'b0; reset = 1'b0;
        step();
        chk("midexc_rst_pc",    pc, 32'h0);
        chk("midexc_rst_busy",  {31'd0, exc_busy}, 32'h0);
        chk("midexc_rst_ack",   {31'd0, exc_ack}, 32'h0);
        chk("midexc_rst_epc",   epc, 32'h0);
        chk("midexc_rst_cause", {30'd0, cause}, 32'h0);
        reset = 1'b1;
        step();
        chk("post_rst_ack", {31'd0, exc_ack}, 32'h0);
        chk("post_rst_pc",  pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
